// File: rtl/sp_add_sequencer.sv
// Initiator for an external FP32 start/done adder: folds a valid/ready element stream
// into a single running sum, sticky-ORing the adder's IEEE flags along the way.
module sp_add_sequencer #(
  parameter int COUNT_W        = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_sub,
  input  logic               in_last,
  input  logic [2:0]         rounding_mode,
  output logic               add_start,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  output logic               add_sub,
  output logic [2:0]         add_rm,
  input  logic [31:0]        add_result,
  input  logic [3:0]         add_flags,
  input  logic               add_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_sum,
  output logic [3:0]         out_flags,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;

  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [2:0]         state_reg;
  logic [31:0]        acc_reg;
  logic [3:0]         flags_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               last_reg;
  logic               first_reg;
  logic [WD_W-1:0]    wd_reg;

  logic [31:0]        add_a_reg;
  logic [31:0]        add_b_reg;
  logic               add_sub_reg;
  logic [2:0]         add_rm_reg;
  logic [31:0]        out_sum_reg;
  logic [3:0]         out_flags_reg;
  logic [COUNT_W-1:0] out_count_reg;
  logic               out_timeout_reg;

  logic [3:0]         flags_next;

  // Handshake/strobe outputs decode straight from the state register, so they are glitch-free
  // and automatically zero while in reset (state is IDLE).
  assign in_ready    = (state_reg == S_ACCEPT);
  assign add_start   = (state_reg == S_ISSUE);
  assign out_valid   = (state_reg == S_OUTPUT);

  assign add_a       = add_a_reg;
  assign add_b       = add_b_reg;
  assign add_sub     = add_sub_reg;
  assign add_rm      = add_rm_reg;
  assign out_sum     = out_sum_reg;
  assign out_flags   = out_flags_reg;
  assign out_count   = out_count_reg;
  assign out_timeout = out_timeout_reg;

  assign flags_next  = flags_reg | add_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      acc_reg         <= 32'h0000_0000;
      flags_reg       <= 4'h0;
      count_reg       <= '0;
      last_reg        <= 1'b0;
      first_reg       <= 1'b1;
      wd_reg          <= '0;
      add_a_reg       <= 32'h0;
      add_b_reg       <= 32'h0;
      add_sub_reg     <= 1'b0;
      add_rm_reg      <= 3'b000;
      out_sum_reg     <= 32'h0;
      out_flags_reg   <= 4'h0;
      out_count_reg   <= '0;
      out_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          acc_reg   <= 32'h0000_0000;
          flags_reg <= 4'h0;
          count_reg <= '0;
          first_reg <= 1'b1;
          state_reg <= S_ACCEPT;
        end

        S_ACCEPT: begin
          if (in_valid) begin
            add_a_reg   <= acc_reg;
            add_b_reg   <= in_data;
            add_sub_reg <= in_sub;
            last_reg    <= in_last;
            first_reg   <= 1'b0;
            // Rounding mode is a per-reduction property; later elements' values are ignored.
            if (first_reg) add_rm_reg <= rounding_mode;
            if (count_reg != COUNT_MAX) count_reg <= count_reg + COUNT_W'(1);
            state_reg   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wd_reg    <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (add_done) begin
            // Flags are only meaningful in the done cycle; the adder clears them afterwards.
            acc_reg   <= add_result;
            flags_reg <= flags_next;
            if (last_reg) begin
              out_sum_reg     <= add_result;
              out_flags_reg   <= flags_next;
              out_count_reg   <= count_reg;
              out_timeout_reg <= 1'b0;
              state_reg       <= S_OUTPUT;
            end else begin
              state_reg <= S_ACCEPT;
            end
          end else if (wd_reg == WD_LAST) begin
            // Abort: report the last good accumulator; any late add_done lands outside WAIT.
            out_sum_reg     <= acc_reg;
            out_flags_reg   <= flags_reg;
            out_count_reg   <= count_reg;
            out_timeout_reg <= 1'b1;
            state_reg       <= S_OUTPUT;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end

        S_OUTPUT: begin
          if (out_ready) state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_add_sequencer.sv
// Scoreboarded bench for sp_add_sequencer with a table-driven stub adder of configurable latency.
`timescale 1ns/1ps
module tb_sp_add_sequencer;
  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid, in_ready, in_sub, in_last;
  logic [31:0]        in_data;
  logic [2:0]         rounding_mode;
  logic               add_start, add_sub, add_done;
  logic [31:0]        add_a, add_b, add_result;
  logic [2:0]         add_rm;
  logic [3:0]         add_flags;
  logic               out_valid, out_ready, out_timeout;
  logic [31:0]        out_sum;
  logic [3:0]         out_flags;
  logic [COUNT_W-1:0] out_count;

  always #5 clk = ~clk;

  sp_add_sequencer #(.COUNT_W(COUNT_W), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
    .in_last(in_last), .rounding_mode(rounding_mode),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_rm(add_rm),
    .add_result(add_result), .add_flags(add_flags), .add_done(add_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_flags(out_flags),
    .out_count(out_count), .out_timeout(out_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_starts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stub adder ----------------
  int          stub_lat   = 3;
  logic        stub_dead  = 1'b0;
  logic        force_done = 1'b0;
  logic        stub_busy, stub_done, cap_sub;
  int          stub_cnt;
  logic [31:0] cap_a, cap_b, stub_res;
  logic [2:0]  cap_rm;
  logic [3:0]  stub_flags;
  logic [2:0]  exp_rm = 3'b000;

  // Hand-computed IEEE-754 results for the operand pairs the directed tests produce.
  function automatic logic [35:0] adder_lookup(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
    case ({a, b, s})
      {32'h0000_0000, 32'h3F80_0000, 1'b0}: return {32'h3F80_0000, 4'b0000};
      {32'h3F80_0000, 32'h4000_0000, 1'b0}: return {32'h4040_0000, 4'b0000};
      {32'h4040_0000, 32'h4040_0000, 1'b0}: return {32'h40C0_0000, 4'b0000};
      {32'h0000_0000, 32'h7F7F_FFFF, 1'b0}: return {32'h7F7F_FFFF, 4'b0000};
      {32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0}: return {32'h7F80_0000, 4'b0101};
      {32'h0000_0000, 32'h7F80_0000, 1'b0}: return {32'h7F80_0000, 4'b0000};
      {32'h7F80_0000, 32'h7F80_0000, 1'b1}: return {32'h7FC0_0000, 4'b1000};
      {32'h0000_0000, 32'h4000_0000, 1'b0}: return {32'h4000_0000, 4'b0000};
      {32'h0000_0000, 32'h3F80_0000, 1'b1}: return {32'hBF80_0000, 4'b0000};
      default:                              return {32'hBAD0_BAD0, 4'b0000};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 1'b0; stub_done <= 1'b0; stub_cnt <= 0;
      stub_res <= 32'h0; stub_flags <= 4'h0;
      cap_a <= 32'h0; cap_b <= 32'h0; cap_sub <= 1'b0; cap_rm <= 3'b000;
    end else begin
      stub_done <= 1'b0;
      if (add_start && !stub_dead) begin
        stub_busy <= 1'b1; stub_cnt <= stub_lat;
        cap_a <= add_a; cap_b <= add_b; cap_sub <= add_sub; cap_rm <= add_rm;
      end else if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy <= 1'b0;
          stub_done <= 1'b1;
          {stub_res, stub_flags} <= adder_lookup(cap_a, cap_b, cap_sub);
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  // Garbage outside the done cycle exposes any sampling in the wrong cycle.
  assign add_done   = stub_done | force_done;
  assign add_result = stub_done ? stub_res : 32'hDEAD_BEEF;
  assign add_flags  = stub_done ? stub_flags : 4'hF;

  // Adder-side protocol monitor.
  always @(negedge clk) begin
    if (add_start) n_starts <= n_starts + 1;
    if (rst_n && add_start) begin
      chk("start_while_busy", 32'({stub_busy, stub_done}), 32'd0);
      chk("add_rm", 32'(add_rm), 32'(exp_rm));
    end
    if (rst_n && stub_busy) begin
      chk("add_a_stable", add_a, cap_a);
      chk("add_b_stable", add_b, cap_b);
      chk("add_sub_stable", 32'(add_sub), 32'(cap_sub));
      chk("add_rm_stable", 32'(add_rm), 32'(cap_rm));
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0]        sum;
    logic [3:0]         flags;
    logic [COUNT_W-1:0] count;
    logic               to;
  } exp_t;

  exp_t               sb[$];
  exp_t               e;
  logic               holding = 1'b0;
  logic [31:0]        h_sum;
  logic [3:0]         h_flags;
  logic [COUNT_W-1:0] h_count;
  logic               h_to;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("in_ready_at_output", 32'(in_ready), 32'd0);
      if (holding) begin
        chk("hold_sum", out_sum, h_sum);
        chk("hold_flags", 32'(out_flags), 32'(h_flags));
        chk("hold_count", 32'(out_count), 32'(h_count));
        chk("hold_timeout", 32'(out_timeout), 32'(h_to));
      end
      if (out_ready) begin
        holding = 1'b0;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got sum 0x%08h with no expected result queued", out_sum);
        end else begin
          e = sb.pop_front();
          $display("result: sum=0x%08h flags=%b count=%0d timeout=%0d", out_sum, out_flags,
                   out_count, out_timeout);
          chk("out_sum", out_sum, e.sum);
          chk("out_flags", 32'(out_flags), 32'(e.flags));
          chk("out_count", 32'(out_count), 32'(e.count));
          chk("out_timeout", 32'(out_timeout), 32'(e.to));
        end
      end else begin
        holding = 1'b1;
        h_sum = out_sum; h_flags = out_flags; h_count = out_count; h_to = out_timeout;
      end
    end else begin
      holding = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] d, input logic s, input logic l, input logic [2:0] rm);
    int n = 0;
    in_data = d; in_sub = s; in_last = l; rounding_mode = rm; in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 500);
    chk("send_accepted", 32'(in_ready), 32'd1);
    $display("elem: data=0x%08h sub=%0d last=%0d rm=%b", d, s, l, rm);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 32'h0; in_sub = 1'b0; in_last = 1'b0; rounding_mode = 3'b111;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin @(negedge clk); n++; end
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_add_start"}, 32'(add_start), 32'd0);
    chk({tag, "_add_a"}, add_a, 32'd0);
    chk({tag, "_add_b"}, add_b, 32'd0);
    chk({tag, "_add_sub"}, 32'(add_sub), 32'd0);
    chk({tag, "_add_rm"}, 32'(add_rm), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_sum"}, out_sum, 32'd0);
    chk({tag, "_out_flags"}, 32'(out_flags), 32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
    chk({tag, "_out_timeout"}, 32'(out_timeout), 32'd0);
  endtask

  initial begin
    int s0, t0, t1, n;
    in_valid = 1'b0; in_data = 32'h0; in_sub = 1'b0; in_last = 1'b0;
    rounding_mode = 3'b111; out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1 + 2 + 3 under RNE; later elements carry other modes that must be ignored.
    exp_rm = 3'b000;
    sb.push_back('{32'h40C0_0000, 4'b0000, 16'd3, 1'b0});
    send(32'h3F80_0000, 1'b0, 1'b0, 3'b000);
    send(32'h4000_0000, 1'b0, 1'b0, 3'b010);
    send(32'h4040_0000, 1'b0, 1'b1, 3'b001);
    drain();

    // MAX_FLOAT + MAX_FLOAT overflows to +inf with overflow|inexact.
    exp_rm = 3'b011;
    sb.push_back('{32'h7F80_0000, 4'b0101, 16'd2, 1'b0});
    send(32'h7F7F_FFFF, 1'b0, 1'b0, 3'b011);
    send(32'h7F7F_FFFF, 1'b0, 1'b1, 3'b000);
    drain();

    // inf - inf -> qNaN, invalid; consumer stalls 20 cycles at OUTPUT.
    exp_rm = 3'b001; stub_lat = 1; out_ready = 1'b0; s0 = n_starts;
    sb.push_back('{32'h7FC0_0000, 4'b1000, 16'd2, 1'b0});
    send(32'h7F80_0000, 1'b0, 1'b0, 3'b001);
    send(32'h7F80_0000, 1'b1, 1'b1, 3'b100);
    wait_out_valid();
    repeat (20) @(negedge clk);
    chk("starts_per_element", 32'(n_starts - s0), 32'd2);
    out_ready = 1'b1;
    drain();

    // Single-element subtraction: +0 - 1.0 = -1.0.
    exp_rm = 3'b100; stub_lat = 4;
    sb.push_back('{32'hBF80_0000, 4'b0000, 16'd1, 1'b0});
    send(32'h3F80_0000, 1'b1, 1'b1, 3'b100);
    drain();

    // Dead adder: watchdog aborts after 64 WAIT cycles; a late done must not disturb the result.
    exp_rm = 3'b000; stub_dead = 1'b1; out_ready = 1'b0;
    sb.push_back('{32'h0000_0000, 4'b0000, 16'd1, 1'b1});
    send(32'h3F80_0000, 1'b0, 1'b1, 3'b000);
    n = 0;
    while (!add_start && n < 20) begin @(negedge clk); n++; end
    chk("timeout_issue_seen", 32'(add_start), 32'd1);
    t0 = cyc;
    wait_out_valid();
    t1 = cyc;
    chk("timeout_latency", 32'(t1 - t0), 32'd65);
    @(posedge clk); #1 force_done = 1'b1;
    @(posedge clk); #1 force_done = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    drain();
    stub_dead = 1'b0;

    // Async reset while the second element is in flight, then a fresh reduction from +0.
    stub_lat = 20; exp_rm = 3'b000;
    send(32'h3F80_0000, 1'b0, 1'b0, 3'b000);
    send(32'h4000_0000, 1'b0, 1'b0, 3'b000);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop_reset");
    s0 = n_starts;
    repeat (3) @(negedge clk);
    chk("no_start_in_reset", 32'(n_starts - s0), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    stub_lat = 3;
    sb.push_back('{32'h4000_0000, 4'b0000, 16'd1, 1'b0});
    send(32'h4000_0000, 1'b0, 1'b1, 3'b000);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "global timeout");
  end

endmodule
